muldiv_ctrl: RTL and testbench

- Multicycle multiply/divide sequencer for the multicycle processor. It sits beside logic_unit and is driven by the control unit.
- Latches two 32-bit operands on a start request and runs a 32-iteration shift-add multiply or restoring divide FSM.
- Writes the 64-bit result into the HI/LO registers.
- Reports completion and divide-by-zero back to the control unit so it can stall and resume.

---
 rtl/muldiv_ctrl_if.sv | 18 +
 rtl/muldiv_ctrl.sv | 156 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// rtl/muldiv_ctrl_if.sv - Request/result bundle between the control unit and muldiv_ctrl
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic             abort;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output start, op, abort, SrcA, SrcB,
                  input  busy, done, div_zero, HI, LO);
  modport slave  (input  start, op, abort, SrcA, SrcB,
                  output busy, done, div_zero, HI, LO);
endinterface

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - Multicycle shift-add multiply / restoring divide sequencer with HI/LO
// Optional MULDIV_EARLY_TERM_EN: multiply leaves RUN once the remaining multiplier bits are zero.
module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic               neg_res;
  logic               neg_dvd;
  logic               dz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic               is_div;
  logic               is_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_trial;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];

  always_comb begin
    a_mag    = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag    = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    // Multiply: b_q is the shifting multiplier, acc collects the product from the top down.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){b_q[0]}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {rem, quot}; rem_sh carries the extra bit shifted out of rem.
    rem_sh    = acc[2*WIDTH-1:WIDTH-1];
    rem_trial = rem_sh[WIDTH-1:0] - b_q;
    if (rem_sh >= {1'b0, b_q})
      div_next = {rem_trial, acc[WIDTH-2:0], 1'b1};
    else
      div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

    prod_fix = neg_res ? -acc : acc;
    if (is_div) begin
      hi_fix = neg_dvd ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      lo_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

`ifdef MULDIV_EARLY_TERM_EN
  logic [CNT_W:0] sh_amt;
  assign sh_amt = {1'b0, cnt} + (CNT_W+1)'(1);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      neg_dvd <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (bus.abort) begin
      // Abort also blocks a start sampled in IDLE.
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state <= S_PREP;
            op_q  <= bus.op;
            a_q   <= bus.SrcA;
            b_q   <= bus.SrcB;
            dz_q  <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_PREP: begin
          a_q     <= a_mag;
          b_q     <= b_mag;
          neg_res <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_dvd <= is_signed & a_q[WIDTH-1];
          cnt     <= CNT_W'(WIDTH-1);
          acc     <= is_div ? {{WIDTH{1'b0}}, a_mag} : '0;
          // Divide-by-zero passes through FIX without writing so DONE lands two edges after accept.
          if (is_div && (b_q == '0)) begin
            dz_q  <= 1'b1;
            state <= S_FIX;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            acc <= div_next;
          end else begin
            acc <= mul_next;
            b_q <= b_q >> 1;
          end
          if (cnt == '0)
            state <= S_FIX;
`ifdef MULDIV_EARLY_TERM_EN
          if (!is_div && (b_q == '0)) begin
            acc   <= acc >> sh_amt;
            state <= S_FIX;
          end
`endif
        end
        S_FIX: begin
          if (!dz_q) begin
            hi_q <= hi_fix;
            lo_q <= lo_fix;
          end
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == S_PREP) || (state == S_RUN) || (state == S_FIX);
  assign bus.done     = (state == S_DONE);
  assign bus.div_zero = (state == S_DONE) && dz_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - Directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   n;
  int   cnt_busy;
  int   cnt_done;

  muldiv_ctrl_if bus();
  muldiv_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edge is E0; inputs are scrambled afterwards to prove they were latched.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.SrcA  = ~a;
    bus.SrcB  = ~b;
    bus.op    = ~op;
  endtask

  task automatic wait_done(input int limit, output int edges);
    edges = 0;
    while (edges < limit) begin
      tick();
      edges++;
      if (bus.done === 1'b1) break;
    end
    if (bus.done !== 1'b1) edges = -1;
  endtask

  task automatic run_chk(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    int e;
    issue(op, a, b);
    wait_done(40, e);
    chk({tag, "_lat"}, e, 34);
    chk({tag, "_hi"}, bus.HI, hi);
    chk({tag, "_lo"}, bus.LO, lo);
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op    = 2'b00;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dz", bus.div_zero, 0);
    chk("rst_hi", bus.HI, 0);
    chk("rst_lo", bus.LO, 0);
    #3 reset = 1'b1;
    tick();

    // MULT -2 x 3 with full timing profile
    issue(2'b00, 32'hFFFF_FFFE, 32'd3);
    cnt_busy = 0;
    cnt_done = 0;
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (bus.busy === 1'b1) cnt_busy++;
      if (bus.done === 1'b1) cnt_done++;
    end
    chk("mult_busy_e1_e33", cnt_busy, 33);
    chk("mult_no_early_done", cnt_done, 0);
    tick();
    chk("mult_done_e34", bus.done, 1);
    chk("mult_busy_e34", bus.busy, 0);
    chk("mult_dz", bus.div_zero, 0);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFFA);
    tick();
    chk("mult_done_once", bus.done, 0);

    run_chk("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_chk("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // Still in DONE: back-to-back accept
    run_chk("divu_7_2", 2'b11, 32'd7, 32'd2, 32'd1, 32'd3);
    run_chk("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_chk("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_chk("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_chk("divu_rem", 2'b11, 32'h1234_5678, 32'h8000_0000, 32'h1234_5678, 32'h0000_0000);
    tick();

    // Divide by zero
    issue(2'b10, 32'd5, 32'd0);
    wait_done(10, n);
    chk("dz_lat", n, 2);
    chk("dz_flag", bus.div_zero, 1);
    chk("dz_hi", bus.HI, 32'h1234_5678);
    chk("dz_lo", bus.LO, 32'h0000_0000);
    tick();
    chk("dz_busy_after", bus.busy, 0);
    chk("dz_done_after", bus.done, 0);
    chk("dz_flag_after", bus.div_zero, 0);

    // Ignored restart at E5, abort at E10
    issue(2'b00, 32'd6, 32'd7);
    repeat (4) tick();
    bus.op    = 2'b01;
    bus.SrcA  = 32'd9;
    bus.SrcB  = 32'd9;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_ignored_busy", bus.busy, 1);
    repeat (4) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_idle", bus.busy, 0);
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) cnt_done++;
    end
    chk("abort_no_done", cnt_done, 0);
    chk("abort_hi", bus.HI, 32'h1234_5678);
    chk("abort_lo", bus.LO, 32'h0000_0000);

    run_chk("mult_6_7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42);
    tick();

    // MULTU by 1: latency depends on the early-termination build option
    issue(2'b01, 32'hDEAD_BEEF, 32'd1);
    wait_done(40, n);
`ifdef MULDIV_EARLY_TERM_EN
    chk("et_early", (n > 0) && (n < 34), 1);
`else
    chk("et_fixed", n, 34);
`endif
    chk("et_hi", bus.HI, 32'h0000_0000);
    chk("et_lo", bus.LO, 32'hDEAD_BEEF);
    tick();

    // Asynchronous reset in the middle of a fresh op
    issue(2'b01, 32'd6, 32'd7);
    repeat (19) tick();
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_hi", bus.HI, 0);
    chk("arst_lo", bus.LO, 0);
    tick();
    reset = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) cnt_done++;
    end
    chk("arst_no_resume", cnt_done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
